// File: rtl/result_frame_tx.sv
// Result frame transmitter: on each inference completion sends header, digit,
// score bytes from scores_ram and an XOR checksum through the shared uart_tx.
module result_frame_tx #(
  parameter logic [7:0]  HEADER_BYTE     = 8'hA5,
  parameter int unsigned NUM_SCORE_BYTES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit,
  output logic [5:0] scores_addr,
  input  logic [7:0] scores_data,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic       active,
  output logic       frame_done,
  output logic       pending
);

  localparam logic [5:0] IDX_LAST_SCORE = 6'(NUM_SCORE_BYTES + 1);
  localparam logic [5:0] IDX_CSUM       = 6'(NUM_SCORE_BYTES + 2);
  localparam logic [5:0] IDX_DONE       = 6'(NUM_SCORE_BYTES + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [5:0] r_idx;
  logic [7:0] r_csum;
  logic [3:0] r_digit;
  logic [3:0] r_pend_digit;
  logic       r_pending;
  logic [7:0] r_tx_data;
  logic       r_tx_send;
  logic       r_active;
  logic       r_frame_done;
  logic [5:0] r_scores_addr;

  logic [5:0] w_idx_next;
  logic [7:0] w_byte;

  assign w_idx_next = r_idx + 6'd1;

  // Byte selected for the current frame position.
  always_comb begin
    w_byte = HEADER_BYTE;
    if (r_idx == 6'd0)          w_byte = HEADER_BYTE;
    else if (r_idx == 6'd1)     w_byte = {4'h0, r_digit};
    else if (r_idx == IDX_CSUM) w_byte = r_csum;
    else                        w_byte = scores_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= 6'd0;
      r_csum        <= 8'h00;
      r_digit       <= 4'h0;
      r_pend_digit  <= 4'h0;
      r_pending     <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_send     <= 1'b0;
      r_active      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_scores_addr <= 6'd0;
    end else begin
      r_tx_send    <= 1'b0;
      r_frame_done <= 1'b0;

      // Depth-1 queue; starts arriving while already queued are dropped.
      if (start && (r_state != S_IDLE) && (r_state != S_DONE) && !r_pending) begin
        r_pending    <= 1'b1;
        r_pend_digit <= digit;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_digit  <= digit;
            r_idx    <= 6'd0;
            r_csum   <= 8'h00;
            r_active <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_tx_data <= w_byte;
          if ((r_idx != 6'd0) && (r_idx != IDX_CSUM)) r_csum <= r_csum ^ w_byte;
          r_scores_addr <= 6'd0;
          r_state       <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            r_tx_send <= 1'b1;
            r_state   <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: if (tx_busy) r_state <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (!tx_busy) begin
            r_idx <= w_idx_next;
            if (w_idx_next == IDX_DONE) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else if ((w_idx_next >= 6'd2) && (w_idx_next <= IDX_LAST_SCORE)) begin
              r_scores_addr <= w_idx_next - 6'd2;
              r_state       <= S_FETCH;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          // A queued start, or one landing in this cycle, chains straight into a new frame.
          if (r_pending || start) begin
            r_digit   <= r_pending ? r_pend_digit : digit;
            r_pending <= 1'b0;
            r_idx     <= 6'd0;
            r_csum    <= 8'h00;
            r_state   <= S_LOAD;
          end else begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign scores_addr = r_scores_addr;
  assign tx_data     = r_tx_data;
  assign tx_send     = r_tx_send;
  assign active      = r_active;
  assign frame_done  = r_frame_done;
  assign pending     = r_pending;

endmodule

// File: tb/tb_result_frame_tx.sv
// Directed bench for result_frame_tx with a scores_ram model and a uart_tx busy model.
module tb_result_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] digit;
  logic [5:0] scores_addr;
  logic [7:0] scores_data;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic       active;
  logic       frame_done;
  logic       pending;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [64];
  logic [7:0] sent [$];
  int         busy_cnt = 0;
  int         viol = 0;
  int         fd_cnt = 0;

  result_frame_tx dut (
    .clk(clk), .rst(rst), .start(start), .digit(digit),
    .scores_addr(scores_addr), .scores_data(scores_data),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .active(active), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  // scores_ram: one-cycle read latency
  always @(posedge clk) scores_data <= mem[scores_addr];

  // uart_tx: busy for 10 cycles starting the cycle after a send
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_send) begin
      sent.push_back(tx_data);
      if (tx_busy) viol++;
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [3:0] d);
    @(negedge clk);
    start = 1'b1;
    digit = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sends(input int n, input bit tog);
    int budget = 4000;
    while (sent.size() < n && budget > 0) begin
      @(negedge clk);
      if (tog) digit = digit ^ 4'hF;
      budget--;
    end
    if (budget == 0) check("timeout_sends", 32'(sent.size()), 32'(n));
  endtask

  task automatic check_frame(input int base, input logic [3:0] d, input string tag);
    logic [7:0] cs;
    if (sent.size() < base + 43) begin
      check({tag, "_len"}, 32'(sent.size()), 32'(base + 43));
      return;
    end
    cs = {4'h0, d};
    for (int i = 0; i < 40; i++) cs = cs ^ 8'(i);
    check({tag, "_hdr"}, 32'(sent[base]), 32'hA5);
    check({tag, "_digit"}, 32'(sent[base + 1]), 32'(d));
    for (int i = 0; i < 40; i++)
      check($sformatf("%s_score%0d", tag, i), 32'(sent[base + 2 + i]), 32'(i));
    check({tag, "_csum"}, 32'(sent[base + 42]), 32'(cs));
  endtask

  initial begin
    int base;
    int lat;
    int fd0;
    int budget;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    rst = 1'b1;
    start = 1'b0;
    digit = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_tx_send", 32'(tx_send), 0);
    check("rst_active", 32'(active), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_addr", 32'(scores_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, digit 7, digit toggled during the frame; also latency.
    base = sent.size();
    pulse_start(4'd7);
    check("active_after_start", 32'(active), 1);
    lat = 0;
    while (!tx_send && lat < 10) begin
      @(negedge clk);
      digit = digit ^ 4'hF;
      lat++;
    end
    check("first_send_latency", 32'(lat), 2);
    wait_sends(base + 43, 1'b1);
    repeat (40) @(negedge clk);
    check_frame(base, 4'd7, "f1");
    check("f1_count", 32'(sent.size() - base), 43);
    check("f1_frame_done", 32'(fd_cnt), 1);
    check("f1_busy_viol", 32'(viol), 0);
    check("f1_active_end", 32'(active), 0);

    // Queued start at byte 20, third start dropped.
    base = sent.size();
    fd0 = fd_cnt;
    pulse_start(4'd3);
    wait_sends(base + 20, 1'b0);
    pulse_start(4'd9);
    check("pend_set", 32'(pending), 1);
    pulse_start(4'd5);
    wait_sends(base + 86, 1'b0);
    repeat (200) @(negedge clk);
    check_frame(base, 4'd3, "p1");
    check_frame(base + 43, 4'd9, "p2");
    check("pend_count", 32'(sent.size() - base), 86);
    check("pend_frame_done", 32'(fd_cnt - fd0), 2);
    check("pend_clear", 32'(pending), 0);

    // Async reset at byte 30 with a frame queued.
    base = sent.size();
    pulse_start(4'd2);
    wait_sends(base + 30, 1'b0);
    pulse_start(4'd8);
    rst = 1'b1;
    #1;
    check("arst_tx_send", 32'(tx_send), 0);
    check("arst_active", 32'(active), 0);
    check("arst_pending", 32'(pending), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    base = sent.size();
    pulse_start(4'd4);
    wait_sends(base + 43, 1'b0);
    repeat (200) @(negedge clk);
    check_frame(base, 4'd4, "r1");
    check("r1_count", 32'(sent.size() - base), 43);

    // start coincident with DONE chains into the next frame.
    base = sent.size();
    fd0 = fd_cnt;
    pulse_start(4'd1);
    budget = 4000;
    while (!frame_done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("done_seen", 32'(frame_done), 1);
    start = 1'b1;
    digit = 4'd6;
    @(negedge clk);
    start = 1'b0;
    check("done_chain_active", 32'(active), 1);
    wait_sends(base + 86, 1'b0);
    repeat (200) @(negedge clk);
    check_frame(base, 4'd1, "d1");
    check_frame(base + 43, 4'd6, "d2");
    check("done_frame_done", 32'(fd_cnt - fd0), 2);
    check("all_busy_viol", 32'(viol), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
